// File: rtl/vga_frame_reader_if.sv
// ---------------------------------------------------------------------------
// vga_frame_reader_if
// Signal bundle between the frame reader, RAM port B and the VGA DAC pins.
// master: the frame reader (drives the address and all VGA outputs).
// slave : the RAM/board side (returns read_data, consumes VGA outputs).
// ---------------------------------------------------------------------------
interface vga_frame_reader_if #(
  parameter int ADDR_W = 16
);

  // RAM port B
  logic [ADDR_W-1:0] pixel_address;
  logic [7:0]        read_data;

  // VGA DAC side
  logic              vga_clk;
  logic              hsync;
  logic              vsync;
  logic              blank_n;
  logic              sync_n;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              frame_start;

  modport master (
    output pixel_address,
    input  read_data,
    output vga_clk,
    output hsync,
    output vsync,
    output blank_n,
    output sync_n,
    output red,
    output green,
    output blue,
    output frame_start
  );

  modport slave (
    input  pixel_address,
    output read_data,
    input  vga_clk,
    input  hsync,
    input  vsync,
    input  blank_n,
    input  sync_n,
    input  red,
    input  green,
    input  blue,
    input  frame_start
  );

endinterface

// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
// Display-side reader of the dual-port pixel RAM (owns port B). Generates
// 640x480@60 timing from a clk/2 pixel tick, walks a raster address over the
// top-left anchored image and drives grayscale RGB plus syncs to the DAC.
//
// Pipeline (all stages advance on the pixel tick only):
//   stage 0 : combinational decode of h/v counters
//   stage 1 : registered RAM address + delayed hs/vs/vis/img
//   stage 2 : registered RGB (RAM data or background) + syncs/blank
// Outputs lag the counters by 2 pixel ticks (4 clk), syncs and RGB aligned.
//
// Optional build macro: VGA_SCALE2_EN
//   defined   -> each image pixel is shown as a 2x2 block
//   undefined -> 1:1 mapping
// ---------------------------------------------------------------------------
module vga_frame_reader #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter int         IMG_W    = 256,
  parameter int         IMG_H    = 256,
  parameter int         ADDR_W   = 16,
  parameter logic [7:0] BG_VALUE = 8'h00
) (
  input logic               clk,
  input logic               rst,
  vga_frame_reader_if.master vga
);

  // -------------------------------------------------------------------------
  // Derived timing constants
  // -------------------------------------------------------------------------
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              tick_q;
  logic              vga_clk_q;
  logic              frame_start_q;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;

  // stage 1
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic              hs1_q, vs1_q, vis1_q, img1_q;

  // stage 2
  logic [7:0]        gray2_q, gray2_d;
  logic              hs2_q, vs2_q, vis2_q;

  // stage 0 decode
  logic [31:0]       h_ext, v_ext;
  logic              hs0, vs0, vis0, img0;
  logic [ADDR_W-1:0] addr0;

  assign h_ext = 32'(h_cnt_q);
  assign v_ext = 32'(v_cnt_q);

  // Stage 0: raw sync, visibility, image-region and address from counters
  always_comb begin
    hs0  = !((h_ext >= HS_START) && (h_ext <= HS_END));
    vs0  = !((v_ext >= VS_START) && (v_ext <= VS_END));
    vis0 = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
`ifdef VGA_SCALE2_EN
    // The doubled image may extend past the visible area; it is clipped
    // there so RAM data never leaks into the blanking interval.
    img0  = vis0 && (h_ext < 2 * IMG_W) && (v_ext < 2 * IMG_H);
    addr0 = ADDR_W'(((v_ext >> 1) * IMG_W) + (h_ext >> 1));
`else
    img0  = vis0 && (h_ext < IMG_W) && (v_ext < IMG_H);
    addr0 = ADDR_W'((v_ext * IMG_W) + h_ext);
`endif
  end

  // Next raster position: h wraps at the line end and carries into v
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_ext == H_TOTAL - 1) begin
      h_cnt_d = '0;
      if (v_ext == V_TOTAL - 1) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end
  end

  // Stage-1 address: outside the image region address 0 is issued, its
  // data is masked in stage 2 and never displayed
  always_comb begin
    addr1_d = img0 ? addr0 : '0;
  end

  // Stage-2 gray level: RAM data inside the image, background elsewhere in
  // the visible area, black during blanking
  always_comb begin
    gray2_d = 8'h00;
    if (img1_q) begin
      gray2_d = vga.read_data;
    end else if (vis1_q) begin
      gray2_d = BG_VALUE;
    end
  end

  // Pixel tick toggles every clk; vga_clk mirrors ~tick one clk later so the
  // DAC samples in the middle of each pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= 1'b0;
      vga_clk_q <= 1'b1;
    end else begin
      tick_q    <= ~tick_q;
      vga_clk_q <= tick_q;
    end
  end

  // Raster counters advance once per pixel tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (tick_q) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Frame start: high for the single clk in which tick is set at h=0,v=0
  // (counters are stable while tick is low, so the decode is looked ahead)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= ~tick_q && (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  // Stage 1: register address and carry timing flags alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr1_q <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      vis1_q  <= 1'b0;
      img1_q  <= 1'b0;
    end else if (tick_q) begin
      addr1_q <= addr1_d;
      hs1_q   <= hs0;
      vs1_q   <= vs0;
      vis1_q  <= vis0;
      img1_q  <= img0;
    end
  end

  // Stage 2: RAM data has settled one clk after the address, before this tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray2_q <= 8'h00;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      vis2_q  <= 1'b0;
    end else if (tick_q) begin
      gray2_q <= gray2_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      vis2_q  <= vis1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign vga.pixel_address = addr1_q;
  assign vga.vga_clk       = vga_clk_q;
  assign vga.hsync         = hs2_q;
  assign vga.vsync         = vs2_q;
  assign vga.blank_n       = vis2_q;
  assign vga.sync_n        = 1'b0;
  assign vga.red           = gray2_q;
  assign vga.green         = gray2_q;
  assign vga.blue          = gray2_q;
  assign vga.frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_reader
// Runs the reader with a reduced raster geometry (so several whole frames fit
// in a short run) against a RAM filled with random bytes. Expected outputs
// are computed from the clk count since reset release: pixel index = clk/2,
// address issued one pixel later, RGB/syncs two pixels later. Random
// asynchronous resets are asserted mid-frame between clk edges.
// ---------------------------------------------------------------------------
module tb_vga_frame_reader;

  localparam int         H_ACTIVE = 40;
  localparam int         H_FP     = 4;
  localparam int         H_SYNC   = 8;
  localparam int         H_BP     = 4;
  localparam int         V_ACTIVE = 30;
  localparam int         V_FP     = 2;
  localparam int         V_SYNC   = 2;
  localparam int         V_BP     = 3;
  localparam int         IMG_W    = 16;
  localparam int         IMG_H    = 16;
  localparam int         ADDR_W   = 8;
  localparam logic [7:0] BG_VALUE = 8'h5A;

  localparam int H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_PIX = H_TOT * V_TOT;
  localparam int RAM_DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_compared   = 0;
  int n_mismatched = 0;

  vga_frame_reader_if #(.ADDR_W(ADDR_W)) vga_bus ();

  vga_frame_reader #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .BG_VALUE (BG_VALUE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (vga_bus)
  );

  always #5 clk = ~clk;

  // RAM port B: registered read, one clk latency
  logic [7:0] mem [0:RAM_DEPTH-1];
  always @(posedge clk) vga_bus.read_data <= mem[vga_bus.pixel_address];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp, input int e);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s at clk %0d after reset: got %0h expected %0h",
               tag, e, got, exp);
    end
  endtask

  // Is pixel (h,v) inside the displayed image?
  function automatic bit in_img(input int h, input int v);
    bit vis;
    vis = (h < H_ACTIVE) && (v < V_ACTIVE);
`ifdef VGA_SCALE2_EN
    return vis && (h < 2 * IMG_W) && (v < 2 * IMG_H);
`else
    return vis && (h < IMG_W) && (v < IMG_H);
`endif
  endfunction

  // RAM address for image pixel (h,v), wrapped to the address width
  function automatic int ram_addr(input int h, input int v);
`ifdef VGA_SCALE2_EN
    return ((v / 2) * IMG_W + (h / 2)) % RAM_DEPTH;
`else
    return (v * IMG_W + h) % RAM_DEPTH;
`endif
  endfunction

  // Compare every output against the model, e clk edges after reset release
  task automatic check_outputs(input int e);
    int p, s, q, h, v;
    logic [ADDR_W-1:0] a;
    logic [31:0] exp_addr;
    logic [7:0]  exp_gray;
    bit exp_hs, exp_vs, exp_bl, exp_fs, exp_vclk;
    p = e / 2;      // pixel currently held by the counters
    s = p - 1;      // pixel whose address is currently issued
    q = p - 2;      // pixel currently on the outputs
    exp_addr = 32'd0;
    if (s >= 0) begin
      h = s % H_TOT;
      v = (s / H_TOT) % V_TOT;
      if (in_img(h, v)) exp_addr = 32'(ram_addr(h, v));
    end
    exp_gray = 8'h00;
    exp_hs   = 1'b1;
    exp_vs   = 1'b1;
    exp_bl   = 1'b0;
    if (q >= 0) begin
      h = q % H_TOT;
      v = (q / H_TOT) % V_TOT;
      exp_hs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
      exp_vs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
      exp_bl = (h < H_ACTIVE) && (v < V_ACTIVE);
      if (in_img(h, v)) begin
        a = ADDR_W'(ram_addr(h, v));
        exp_gray = mem[a];
      end else if (exp_bl) begin
        exp_gray = BG_VALUE;
      end
    end
    exp_fs   = (e % 2 == 1) && (p % FRAME_PIX == 0);
    exp_vclk = (e % 2 == 0);
    check_eq("pixel_address", 32'(vga_bus.pixel_address), exp_addr, e);
    check_eq("rgb", 32'({vga_bus.red, vga_bus.green, vga_bus.blue}),
             32'({exp_gray, exp_gray, exp_gray}), e);
    check_eq("hs_vs_blank_sync",
             32'({vga_bus.hsync, vga_bus.vsync, vga_bus.blank_n, vga_bus.sync_n}),
             32'({exp_hs, exp_vs, exp_bl, 1'b0}), e);
    check_eq("frame_start", 32'(vga_bus.frame_start), 32'(exp_fs), e);
    check_eq("vga_clk", 32'(vga_bus.vga_clk), 32'(exp_vclk), e);
  endtask

  task automatic fill_ram();
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int e;
    int n_run;
    e = 0;
    fill_ram();

    // power-up reset held for a few clks
    repeat (3) begin
      @(posedge clk);
      #1 check_outputs(0);
    end
    @(negedge clk) rst = 1'b0;

    // two full frames plus a little, then random mid-frame resets
    for (int ph = 0; ph < 6; ph++) begin
      if (ph == 0)      n_run = 2 * 2 * FRAME_PIX + 200;
      else if (ph == 5) n_run = 2 * FRAME_PIX + 60;
      else              n_run = $urandom_range(5000, 60);
      e = 0;
      repeat (n_run) begin
        @(posedge clk);
        e++;
        #1 check_outputs(e);
      end
      $display("phase %0d: %0d clk from reset release, pixel h=%0d v=%0d, compared=%0d mismatched=%0d",
               ph, n_run, (e / 2) % H_TOT, ((e / 2) / H_TOT) % V_TOT,
               n_compared, n_mismatched);
      if (ph == 5) break;
      // asynchronous reset between edges: outputs must clear in this timestep
      #2 rst = 1'b1;
      #1 check_outputs(0);
      fill_ram();
      repeat (3) begin
        @(posedge clk);
        #1 check_outputs(0);
      end
      @(negedge clk) rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
